// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// default sizing, operand/product widths and a one-hot encoder.
package mul_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 32;
  localparam int MAX_REQ     = 8;
  localparam int MCAND_W     = 4;
  localparam int MULT_W      = 16;
  localparam int PROD_W      = 20;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    CAPTURE,
    RELEASE,
    RESP
  } state_t;

  // Index of the lowest set bit; the caller guarantees at most one bit set.
  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bundle: packed per-requester request operands plus the
// one-hot accept/completion pulses and the shared response payload.
interface mul_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);

  logic [N_REQ-1:0]         req_valid;
  logic [MCAND_W*N_REQ-1:0] req_mcand;
  logic [MULT_W*N_REQ-1:0]  req_mult;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         rsp_valid;
  logic [PROD_W-1:0]        rsp_product;
  logic                     rsp_err;

  modport master (
    output req_valid, req_mcand, req_mult,
    input  req_ready, rsp_valid, rsp_product, rsp_err
  );

  modport slave (
    input  req_valid, req_mcand, req_mult,
    output req_ready, rsp_valid, rsp_product, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting bit at or
// after ptr, wrapping around the request vector.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);

  int   idx;
  logic found;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = '0;
    any   = |req;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external 4x16 multiplier among N_REQ requesters: round-robin
// grant, start/hold handshake with the multiplier, timeout abort, response.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  mul_arbiter_if.slave        bus,
  output logic                busy,
  output logic                mul_st,
  output logic [MCAND_W-1:0]  mul_mcand,
  output logic [MULT_W-1:0]   mul_mult,
  input  logic [PROD_W-1:0]   mul_product,
  input  logic                mul_done
);

  localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              state, state_n;
  logic [PTR_W-1:0]    rr_ptr, ptr_n;
  logic [PTR_W-1:0]    idx_q, idx_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                err, err_n;
  logic [MCAND_W-1:0]  mcand_q, mcand_n;
  logic [MULT_W-1:0]   mult_q, mult_n;
  logic [PROD_W-1:0]   result_q, result_n;

  logic [N_REQ-1:0]    grant;
  logic                any_req;
  int                  win;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any_req)
  );

  always_comb begin
    state_n         = state;
    ptr_n           = rr_ptr;
    idx_n           = idx_q;
    cnt_n           = cnt;
    err_n           = err;
    mcand_n         = mcand_q;
    mult_n          = mult_q;
    result_n        = result_q;
    win             = 0;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_product = '0;
    bus.rsp_err     = 1'b0;
    busy            = (state != IDLE);
    mul_st          = 1'b0;
    mul_mcand       = '0;
    mul_mult        = '0;

    if (state inside {ISSUE, WAIT_DONE, CAPTURE, RELEASE}) begin
      mul_mcand = mcand_q;
      mul_mult  = mult_q;
    end

    case (state)
      IDLE: begin
        // No grant while reset is asserted, so outputs stay quiet in reset.
        if (any_req && rst) begin
          bus.req_ready = grant;
          win           = int'(onehot_idx(MAX_REQ'(grant)));
          idx_n         = PTR_W'(win);
          mcand_n       = bus.req_mcand[win*MCAND_W +: MCAND_W];
          mult_n        = bus.req_mult[win*MULT_W +: MULT_W];
          ptr_n         = (win == N_REQ - 1) ? '0 : PTR_W'(win + 1);
          result_n      = '0;
          cnt_n         = '0;
          err_n         = 1'b0;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        mul_st  = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        mul_st = 1'b1;
        if (mul_done) begin
          state_n = CAPTURE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        mul_st   = 1'b1;
        result_n = mul_product;
        state_n  = RELEASE;
      end
      RELEASE: begin
        if (!mul_done) state_n = RESP;
      end
      RESP: begin
        bus.rsp_valid[idx_q] = 1'b1;
        bus.rsp_product      = result_q;
        bus.rsp_err          = err;
        err_n                = 1'b0;
        cnt_n                = '0;
        state_n              = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx_q    <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      mcand_q  <= '0;
      mult_q   <= '0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      idx_q    <= idx_n;
      cnt      <= cnt_n;
      err      <= err_n;
      mcand_q  <= mcand_n;
      mult_q   <= mult_n;
      result_q <= result_n;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural multiplier model;
// grant and response monitors pop hand-computed expectations.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int NR = 4;

  typedef struct {
    int idx;
    int gap;
  } grant_t;

  typedef struct {
    int          idx;
    logic [19:0] prod;
    logic        err;
    int          lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy, mul_st, mul_done;
  logic [3:0]  mul_mcand;
  logic [15:0] mul_mult;
  logic [19:0] mul_product = '0;
  logic [3:0]  mcount = '0;
  logic        no_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int grant_count = 0;
  int last_grant = 0;

  grant_t gq[$];
  rsp_t   rq[$];

  mul_arbiter_if #(.N_REQ(NR)) bus ();

  mul_arbiter #(.N_REQ(NR), .TIMEOUT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .mul_st      (mul_st),
    .mul_mcand   (mul_mcand),
    .mul_mult    (mul_mult),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: loads product on start, raises done after 10 held cycles,
  // drops done one cycle after start is released.
  always @(posedge clk) begin
    if (!rst || !mul_st) begin
      mcount <= '0;
    end else begin
      if (mcount == 4'd0) mul_product <= 20'(mul_mcand) * 20'(mul_mult);
      if (mcount != 4'd15) mcount <= mcount + 4'd1;
    end
  end
  assign mul_done = !no_done && (mcount >= 4'd10);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && |bus.req_ready) begin
      grant_t g;
      grant_count++;
      check("grant_onehot", $countones(bus.req_ready), 1);
      if (gq.size() == 0) begin
        check("unexpected_grant", 32'(oh2i(bus.req_ready)), 32'hFFFF_FFFF);
      end else begin
        g = gq.pop_front();
        check("grant_idx", 32'(oh2i(bus.req_ready)), 32'(g.idx));
        if (g.gap != 0) check("grant_gap", 32'(cyc - last_grant), 32'(g.gap));
      end
      last_grant = cyc;
    end
  end

  always @(negedge clk) begin
    if (|bus.rsp_valid) begin
      rsp_t e;
      check("rsp_onehot", $countones(bus.rsp_valid), 1);
      if (rq.size() == 0) begin
        check("unexpected_rsp", 32'(oh2i(bus.rsp_valid)), 32'hFFFF_FFFF);
      end else begin
        e = rq.pop_front();
        check("rsp_idx", 32'(oh2i(bus.rsp_valid)), 32'(e.idx));
        check("rsp_product", 32'(bus.rsp_product), 32'(e.prod));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - last_grant), 32'(e.lat));
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] mc, input logic [15:0] ml);
    bus.req_mcand[i*4 +: 4]  = mc;
    bus.req_mult[i*16 +: 16] = ml;
    bus.req_valid[i]         = 1'b1;
  endtask

  task automatic expect_op(input int i, input int gap, input logic [19:0] p,
                           input logic e, input int lat);
    grant_t g;
    rsp_t   r;
    g.idx = i; g.gap = gap;
    r.idx = i; r.prod = p; r.err = e; r.lat = lat;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  task automatic wait_grants(input int n, input string name);
    int target;
    target = grant_count + n;
    for (int k = 0; k < 200 && grant_count < target; k++) begin
      @(posedge clk); #1;
    end
    check({"grant_wait_", name}, 32'(grant_count >= target), 1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
    end
    check({"idle_wait_", name}, 32'(busy), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mul_st"}, 32'(mul_st), 0);
    check({tag, "_mul_mcand"}, 32'(mul_mcand), 0);
    check({tag, "_mul_mult"}, 32'(mul_mult), 0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_mcand = '0;
    bus.req_mult  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");

    // All four requesters pending through reset: order 0,1,2,3,0 at 16-cycle spacing.
    set_req(0, 4'h1, 16'h1111);
    set_req(1, 4'h2, 16'h2222);
    set_req(2, 4'h3, 16'h3333);
    set_req(3, 4'h4, 16'h4444);
    expect_op(0, 0,  20'h01111, 1'b0, 15);
    expect_op(1, 16, 20'h04444, 1'b0, 15);
    expect_op(2, 16, 20'h09999, 1'b0, 15);
    expect_op(3, 16, 20'h11110, 1'b0, 15);
    expect_op(0, 16, 20'h01111, 1'b0, 15);
    @(posedge clk); #1;
    check("reset_held_ready", 32'(bus.req_ready), 0);
    rst = 1'b1;
    wait_grants(5, "rr4");
    bus.req_valid = '0;
    wait_idle("rr4");

    // Max operands; requester drops and scrambles inputs after acceptance.
    set_req(0, 4'hF, 16'hFFFF);
    expect_op(0, 0, 20'hEFFF1, 1'b0, 15);
    wait_grants(1, "max");
    set_req(0, 4'h0, 16'h0000);
    bus.req_valid = '0;
    check("op_hold_mcand", 32'(mul_mcand), 32'hF);
    check("op_hold_mult", 32'(mul_mult), 32'hFFFF);
    wait_idle("max");

    // Zero multiplicand on requester 3.
    set_req(3, 4'h0, 16'hABCD);
    expect_op(3, 0, 20'h00000, 1'b0, 15);
    wait_grants(1, "zero");
    bus.req_valid = '0;
    wait_idle("zero");

    // Move rr_ptr to 2 via requester 1, then 1 and 2 compete: 2 wins.
    set_req(1, 4'h2, 16'h0100);
    expect_op(1, 0, 20'h00200, 1'b0, 15);
    wait_grants(1, "ptr");
    bus.req_valid = '0;
    wait_idle("ptr");
    set_req(1, 4'h5, 16'h0010);
    set_req(2, 4'h3, 16'h1234);
    expect_op(2, 0,  20'h0369C, 1'b0, 15);
    expect_op(1, 16, 20'h00050, 1'b0, 15);
    wait_grants(1, "rr_a");
    bus.req_valid[2] = 1'b0;
    wait_grants(1, "rr_b");
    bus.req_valid = '0;
    wait_idle("rr_b");

    // Multiplier never completes: timeout abort with zero product.
    no_done = 1'b1;
    set_req(0, 4'h7, 16'h0003);
    expect_op(0, 0, 20'h00000, 1'b1, 35);
    wait_grants(1, "tmo");
    bus.req_valid = '0;
    wait_idle("tmo");
    no_done = 1'b0;
    check("tmo_busy_low", 32'(busy), 0);

    // Reset during WAIT_DONE: aborted request gets no response, rr_ptr cleared.
    begin
      grant_t g;
      g.idx = 1; g.gap = 0;
      gq.push_back(g);
    end
    set_req(1, 4'h9, 16'h1000);
    wait_grants(1, "abort");
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_wait", 32'(mul_st), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_quiet("midrst");
    repeat (30) @(posedge clk);
    #1;
    check("midrst_still_idle", 32'(busy), 0);
    set_req(1, 4'h9, 16'h1000);
    set_req(2, 4'h1, 16'h0001);
    expect_op(1, 0, 20'h09000, 1'b0, 15);
    wait_grants(1, "post_rst");
    bus.req_valid = '0;
    wait_idle("post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("sb_rsp_empty", 32'(rq.size()), 0);
    check("sb_grant_empty", 32'(gq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
